// File: rtl/prf_ready_file.sv
// Physical register file with per-register ready (scoreboard) bits.
// Writeback sets ready, rename allocation clears it; reads bypass same-cycle writeback data.
module prf_ready_file #(
  parameter int NUM_P_REGS = 64,
  parameter int WORD_SIZE  = 32,
  parameter int NUM_READ   = 4,
  parameter int NUM_WRITE  = 2,
  parameter int NUM_ALLOC  = 2,
  localparam int PW = $clog2(NUM_P_REGS),
  localparam int CW = $clog2(NUM_P_REGS + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_WRITE-1:0]          wr_en_i,
  input  logic [NUM_WRITE*PW-1:0]       wr_dest_i,
  input  logic [NUM_WRITE*WORD_SIZE-1:0] wr_data_i,
  input  logic [NUM_ALLOC-1:0]          alloc_en_i,
  input  logic [NUM_ALLOC*PW-1:0]       alloc_dest_i,
  input  logic [NUM_READ*PW-1:0]        rd_addr_i,
  output logic [NUM_READ*WORD_SIZE-1:0] rd_data_o,
  output logic [NUM_READ-1:0]           rd_ready_o,
  output logic [CW-1:0]                 busy_count_o,
  output logic                          wr_conflict_o
);

  logic [WORD_SIZE-1:0]  rf [NUM_P_REGS];
  logic [NUM_P_REGS-1:0] ready_reg;
  logic [NUM_P_REGS-1:0] ready_next;
  logic [CW-1:0]         busy_count_reg;
  logic [CW-1:0]         busy_count_next;
  logic                  wr_conflict_reg;
  logic                  wr_conflict_next;

  // Ascending port order makes the highest-index port the last (winning) assignment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_P_REGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (wr_en_i[k] && (wr_dest_i[k*PW +: PW] != '0)) begin
          rf[wr_dest_i[k*PW +: PW]] <= wr_data_i[k*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  // Allocs are applied after writes so a same-cycle alloc leaves the register busy.
  always_comb begin
    ready_next = ready_reg;
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (wr_en_i[k] && (wr_dest_i[k*PW +: PW] != '0)) begin
        ready_next[wr_dest_i[k*PW +: PW]] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_ALLOC; k++) begin
      if (alloc_en_i[k] && (alloc_dest_i[k*PW +: PW] != '0)) begin
        ready_next[alloc_dest_i[k*PW +: PW]] = 1'b0;
      end
    end
    ready_next[0] = 1'b1;
    if (rst_i) begin
      ready_next = '1;
    end
  end

  always_comb begin
    busy_count_next = '0;
    for (int i = 0; i < NUM_P_REGS; i++) begin
      busy_count_next = busy_count_next + {{(CW-1){1'b0}}, ~ready_next[i]};
    end
  end

  always_comb begin
    wr_conflict_next = 1'b0;
    for (int a = 0; a < NUM_WRITE; a++) begin
      for (int b = a + 1; b < NUM_WRITE; b++) begin
        if (wr_en_i[a] && wr_en_i[b] &&
            (wr_dest_i[a*PW +: PW] == wr_dest_i[b*PW +: PW]) &&
            (wr_dest_i[a*PW +: PW] != '0)) begin
          wr_conflict_next = 1'b1;
        end
      end
    end
    if (rst_i) begin
      wr_conflict_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_reg       <= '1;
      busy_count_reg  <= '0;
      wr_conflict_reg <= 1'b0;
    end else begin
      ready_reg       <= ready_next;
      busy_count_reg  <= busy_count_next;
      wr_conflict_reg <= wr_conflict_next;
    end
  end

  assign busy_count_o  = busy_count_reg;
  assign wr_conflict_o = wr_conflict_reg;

  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [PW-1:0]        addr;
      logic [WORD_SIZE-1:0] data;
      logic                 rdy;

      assign addr = rd_addr_i[gi*PW +: PW];

      always_comb begin
        data = rf[addr];
        rdy  = ready_reg[addr];
        if (!rst_i && (addr != '0)) begin
          for (int k = 0; k < NUM_WRITE; k++) begin
            if (wr_en_i[k] && (wr_dest_i[k*PW +: PW] == addr)) begin
              data = wr_data_i[k*WORD_SIZE +: WORD_SIZE];
              rdy  = 1'b1;
            end
          end
        end
        if (addr == '0) begin
          data = '0;
          rdy  = 1'b1;
        end
      end

      assign rd_data_o[gi*WORD_SIZE +: WORD_SIZE] = data;
      assign rd_ready_o[gi]                      = rdy;
    end
  endgenerate

endmodule

// File: tb/tb_prf_ready_file.sv
// Bench for prf_ready_file: directed vector table, hand sequences and random stress
// against an array-based scoreboard model.
module tb_prf_ready_file;
  localparam int NP = 32;
  localparam int W  = 32;
  localparam int NR = 6;
  localparam int NW = 3;
  localparam int NA = 2;
  localparam int PW = $clog2(NP);
  localparam int CW = $clog2(NP + 1);

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NW-1:0]        wr_en_i;
  logic [NW*PW-1:0]     wr_dest_i;
  logic [NW*W-1:0]      wr_data_i;
  logic [NA-1:0]        alloc_en_i;
  logic [NA*PW-1:0]     alloc_dest_i;
  logic [NR*PW-1:0]     rd_addr_i;
  logic [NR*W-1:0]      rd_data_o;
  logic [NR-1:0]        rd_ready_o;
  logic [CW-1:0]        busy_count_o;
  logic                 wr_conflict_o;

  prf_ready_file #(
    .NUM_P_REGS(NP), .WORD_SIZE(W), .NUM_READ(NR), .NUM_WRITE(NW), .NUM_ALLOC(NA)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_dest_i(wr_dest_i), .wr_data_i(wr_data_i),
    .alloc_en_i(alloc_en_i), .alloc_dest_i(alloc_dest_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_ready_o(rd_ready_o),
    .busy_count_o(busy_count_o), .wr_conflict_o(wr_conflict_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard model
  logic [W-1:0] m_rf [NP];
  bit           m_rdy [NP];
  int           m_busy;
  bit           m_conf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst;
    int          wen, wd0, wd1;
    logic [31:0] wv0, wv1;
    int          aen, ad0, ad1, ra;
    logic [31:0] exp_rd;
    bit          exp_rdy;
    int          exp_busy;
    bit          exp_conf;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(bit rst, int wen, int wd0, logic [31:0] wv0, int wd1, logic [31:0] wv1,
                              int aen, int ad0, int ad1, int ra,
                              logic [31:0] erd, bit erdy, int ebusy, bit econf);
    vec_t v;
    v.rst = rst; v.wen = wen; v.wd0 = wd0; v.wv0 = wv0; v.wd1 = wd1; v.wv1 = wv1;
    v.aen = aen; v.ad0 = ad0; v.ad1 = ad1; v.ra = ra;
    v.exp_rd = erd; v.exp_rdy = erdy; v.exp_busy = ebusy; v.exp_conf = econf;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst_i        = 1'b0;
    wr_en_i      = '0;
    wr_dest_i    = '0;
    wr_data_i    = '0;
    alloc_en_i   = '0;
    alloc_dest_i = '0;
    rd_addr_i    = '0;
  endtask

  function automatic int rnd_dest();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 3));
    return int'($urandom_range(0, NP - 1));
  endfunction

  // Compare every read port against the model's view of the current cycle.
  task automatic check_reads();
    logic [PW-1:0] a;
    logic [W-1:0]  ed;
    bit            er;
    #1;
    for (int r = 0; r < NR; r++) begin
      a  = rd_addr_i[r*PW +: PW];
      ed = (a == 0) ? '0 : m_rf[a];
      er = (a == 0) ? 1'b1 : m_rdy[a];
      if (!rst_i && a != 0) begin
        for (int k = 0; k < NW; k++) begin
          if (wr_en_i[k] && wr_dest_i[k*PW +: PW] == a) begin
            ed = wr_data_i[k*W +: W];
            er = 1'b1;
          end
        end
      end
      chk($sformatf("rd_data[%0d]", r), rd_data_o[r*W +: W], ed);
      chk($sformatf("rd_ready[%0d]", r), 32'(rd_ready_o[r]), 32'(er));
    end
  endtask

  // Advance the model by one edge, clock the DUT, compare registered outputs.
  task automatic clock_and_check();
    int hits [NP];
    int d;
    if (rst_i) begin
      for (int i = 0; i < NP; i++) begin
        m_rf[i] = '0;
        m_rdy[i] = 1'b1;
      end
      m_conf = 1'b0;
    end else begin
      for (int i = 0; i < NP; i++) hits[i] = 0;
      for (int k = 0; k < NW; k++) begin
        d = int'(wr_dest_i[k*PW +: PW]);
        if (wr_en_i[k] && d != 0) begin
          hits[d]++;
          m_rf[d]  = wr_data_i[k*W +: W];
          m_rdy[d] = 1'b1;
        end
      end
      for (int k = 0; k < NA; k++) begin
        d = int'(alloc_dest_i[k*PW +: PW]);
        if (alloc_en_i[k] && d != 0) m_rdy[d] = 1'b0;
      end
      m_conf = 1'b0;
      for (int i = 1; i < NP; i++) if (hits[i] > 1) m_conf = 1'b1;
    end
    m_busy = 0;
    for (int i = 0; i < NP; i++) if (!m_rdy[i]) m_busy++;
    @(posedge clk_i);
    #1;
    chk("busy_count", 32'(busy_count_o), 32'(m_busy));
    chk("wr_conflict", 32'(wr_conflict_o), 32'(m_conf));
  endtask

  task automatic apply_vec(vec_t v);
    idle();
    rst_i        = v.rst;
    wr_en_i      = NW'(v.wen);
    wr_dest_i    = {PW'(0), PW'(v.wd1), PW'(v.wd0)};
    wr_data_i    = {32'h0, v.wv1, v.wv0};
    alloc_en_i   = NA'(v.aen);
    alloc_dest_i = {PW'(v.ad1), PW'(v.ad0)};
    for (int r = 0; r < NR; r++) rd_addr_i[r*PW +: PW] = PW'((v.ra + r) % NP);
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 0, 0,            0, 0,     3, 5, 9,   5, 0,            1, 2, 0);
    tbl[1]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0,     0, 0, 0,   5, 32'hDEADBEEF, 1, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0,            0, 0,     0, 0, 0,   9, 0,            0, 1, 0);
    tbl[3]  = mk(0, 3, 7, 32'h11,       7, 32'h22, 0, 0, 0,  7, 32'h22,       1, 1, 1);
    tbl[4]  = mk(0, 0, 0, 0,            0, 0,     0, 0, 0,   7, 32'h22,       1, 1, 0);
    tbl[5]  = mk(0, 3, 0, 32'h11,       0, 32'h22, 0, 0, 0,  0, 0,            1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0,            0, 0,     0, 0, 0,   0, 0,            1, 1, 0);
    tbl[7]  = mk(0, 1, 12, 32'h33,      0, 0,     1, 12, 0,  12, 32'h33,      1, 2, 0);
    tbl[8]  = mk(0, 0, 0, 0,            0, 0,     0, 0, 0,   12, 32'h33,      0, 2, 0);
    tbl[9]  = mk(0, 2, 0, 0,            9, 32'h99, 3, 20, 20, 9, 32'h99,      1, 2, 0);
    tbl[10] = mk(1, 3, 3, 32'h44,       3, 32'h55, 3, 3, 4,  3, 0,            1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0,            0, 0,     0, 0, 0,   3, 0,            1, 0, 0);

    // Reset
    idle();
    rst_i = 1'b1;
    @(negedge clk_i);
    clock_and_check();
    rst_i = 1'b1;
    clock_and_check();

    // Every register reads 0 / ready after reset
    for (int i = 0; i < NP; i++) begin
      idle();
      for (int r = 0; r < NR; r++) rd_addr_i[r*PW +: PW] = PW'(i);
      check_reads();
      chk("post_reset_data", rd_data_o[W-1:0], 32'h0);
      chk("post_reset_ready", 32'(rd_ready_o[0]), 32'h1);
      clock_and_check();
      chk("post_reset_busy", 32'(busy_count_o), 32'h0);
    end

    // Directed vector table
    for (int n = 0; n < 12; n++) begin
      apply_vec(tbl[n]);
      check_reads();
      chk($sformatf("vec%0d_rd_data", n), rd_data_o[W-1:0], tbl[n].exp_rd);
      chk($sformatf("vec%0d_rd_ready", n), 32'(rd_ready_o[0]), 32'(tbl[n].exp_rdy));
      clock_and_check();
      chk($sformatf("vec%0d_busy", n), 32'(busy_count_o), 32'(tbl[n].exp_busy));
      chk($sformatf("vec%0d_conflict", n), 32'(wr_conflict_o), 32'(tbl[n].exp_conf));
    end

    // Fill: allocate every nonzero register one per cycle
    for (int i = 1; i < NP; i++) begin
      idle();
      alloc_en_i[0]    = 1'b1;
      alloc_dest_i[PW-1:0] = PW'(i);
      for (int r = 0; r < NR; r++) rd_addr_i[r*PW +: PW] = PW'(rnd_dest());
      check_reads();
      clock_and_check();
      chk("fill_busy", 32'(busy_count_o), 32'(i));
    end
    idle();
    alloc_en_i   = 2'b11;
    alloc_dest_i = {PW'(1), PW'(0)};
    check_reads();
    clock_and_check();
    chk("full_no_wrap", 32'(busy_count_o), 32'(NP - 1));

    // Reset together with a write to p3
    idle();
    rst_i              = 1'b1;
    wr_en_i[0]         = 1'b1;
    wr_dest_i[PW-1:0]  = PW'(3);
    wr_data_i[W-1:0]   = 32'hCAFE0003;
    rd_addr_i[PW-1:0]  = PW'(3);
    check_reads();
    chk("rst_no_bypass_ready", 32'(rd_ready_o[0]), 32'h0);
    clock_and_check();
    chk("rst_busy", 32'(busy_count_o), 32'h0);
    idle();
    for (int r = 0; r < NR; r++) rd_addr_i[r*PW +: PW] = PW'(3 + r);
    check_reads();
    chk("rst_p3_data", rd_data_o[W-1:0], 32'h0);
    chk("rst_p3_ready", 32'(rd_ready_o[0]), 32'h1);
    chk("rst_all_ready", 32'(rd_ready_o), 32'((1 << NR) - 1));
    clock_and_check();

    // Random stress
    for (int n = 0; n < 10000; n++) begin
      idle();
      rst_i = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NW; k++) begin
        wr_en_i[k]          = 1'($urandom_range(0, 1));
        wr_dest_i[k*PW +: PW] = PW'(rnd_dest());
        wr_data_i[k*W +: W] = $urandom;
      end
      for (int k = 0; k < NA; k++) begin
        alloc_en_i[k]          = ($urandom_range(0, 2) == 0);
        alloc_dest_i[k*PW +: PW] = PW'(rnd_dest());
      end
      for (int r = 0; r < NR; r++) rd_addr_i[r*PW +: PW] = PW'(rnd_dest());
      check_reads();
      clock_and_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prf_ready_file.md
# prf_ready_file

Parametrised physical register file with per-register ready (scoreboard) bits for the out-of-order RISC-V core. It has NUM_WRITE writeback ports, NUM_ALLOC rename-allocation ports and NUM_READ issue read ports. Same-cycle write-to-read bypass hides writeback latency from issue. It sits between rename (alloc), the functional-unit writeback bus and the issue queue operand-read stage.

## Interface
- NUM_P_REGS, 64, physical register count (power of two, ≥4); PW = $clog2(NUM_P_REGS)
- WORD_SIZE, 32, data width
- NUM_READ, 4, read ports
- NUM_WRITE, 2, writeback ports
- NUM_ALLOC, 2, allocation ports
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- wr_en_i  in  NUM_WRITE  writeback valid per port
- wr_dest_i  in  NUM_WRITE*PW  writeback destination; port k at [k*PW +: PW]
- wr_data_i  in  NUM_WRITE*WORD_SIZE  writeback data; port k at [k*WORD_SIZE +: WORD_SIZE]
- alloc_en_i  in  NUM_ALLOC  allocation valid per port
- alloc_dest_i  in  NUM_ALLOC*PW  newly renamed destination; marks it not-ready
- rd_addr_i  in  NUM_READ*PW  read address per port
- rd_data_o  out  NUM_READ*WORD_SIZE  read data per port (combinational)
- rd_ready_o  out  NUM_READ  operand-ready per port (combinational)
- busy_count_o  out  $clog2(NUM_P_REGS+1)  number of registers currently not ready (registered)
- wr_conflict_o  out  1  registered pulse: two enabled write ports hit the same nonzero register last cycle

## Operation
- State: data array rf[NUM_P_REGS], ready vector ready_q[NUM_P_REGS], busy_count_o, wr_conflict_o.
- Reset edge (rst_i=1):
  - every rf entry is set to 0 and every ready_q bit to 1.
  - busy_count_o=0, wr_conflict_o=0.
  - All writes and allocs presented that cycle are discarded.
- Register 0 is hardwired:
  - reads return 0 with ready 1.
  - Writes and allocs to register 0 are ignored and never counted as a conflict.
- Writeback: an enabled port with a nonzero dest writes rf[dest] and sets ready_q[dest]=1 at the edge.
- Same-dest writes: if two or more enabled ports target the same nonzero dest, the highest-index port's data wins and wr_conflict_o=1 on the next cycle.
- Alloc: an enabled port with a nonzero dest clears ready_q[dest] at the edge. Duplicate alloc dests are harmless (idempotent).
- Alloc and write to the same register in the same cycle: the alloc wins for ready_q (result 0); rf still takes the write data.
- Read port r with addr a:
  - If rst_i=0 and any enabled write port has dest==a with a≠0, rd_data = that port's data (highest index wins) and rd_ready=1. This is the bypass.
  - Otherwise rd_data=rf[a] and rd_ready=ready_q[a].
  - With rst_i=1 the bypass is disabled and reads return stored state.
  - Allocs never affect same-cycle reads.
- busy_count_o always equals the popcount of ~ready_q after each edge. It is computed from the next-state vector, not incrementally. Range is 0..NUM_P_REGS-1, since register 0 is never busy.

## Timing
- Read latency 0: combinational from rd_addr_i, wr_*_i and state.
- Write/alloc latency 1: visible in stored state after the next rising edge.
- busy_count_o and wr_conflict_o update on the same edge as the state they describe.
- No backpressure. All enables are accepted unconditionally every cycle.
- Reset asserted mid-stream overrides everything on that edge. The first cycle after deassertion presents the fully reset state.
- After reset, outputs are: rd_data_o=0, rd_ready_o=all 1, busy_count_o=0, wr_conflict_o=0.

## Test plan
- Reset, then read registers 0..63 on all ports → data 0, ready 1, busy_count_o=0.
- Alloc p5 and p9 in cycle 0 → busy_count_o=2 and p5 reads ready 0 in cycle 1. In cycle 1, write p5=0xDEADBEEF on port 0 while reading p5 → same-cycle rd_data=0xDEADBEEF and ready 1. In cycle 2 busy_count_o=1.
- Write p7 on port0=0x11 and port1=0x22 in the same cycle → rf[7]=0x22 and wr_conflict_o=1 for exactly one cycle. Repeat the same stimulus targeting p0 → no conflict, p0 still reads 0.
- Alloc p12 and write p12=0x33 in the same cycle → next cycle p12 data 0x33, ready 0, busy_count_o incremented by 1.
- Alloc all 63 nonzero registers over successive cycles → busy_count_o reaches 63 with no wrap. Then assert rst_i together with writes to p3 → next cycle p3=0, all ready, busy_count_o=0.
- Random stress against a reference scoreboard model with NUM_WRITE=3, NUM_READ=6, NUM_P_REGS=32 → zero mismatches over 10k cycles.
